gb80_micro_sequencer: RTL and testbench
=======================================

// Module: gb80_micro_sequencer
// PURPOSE
//  Multi-cycle FSM sequencing the gb80 shared 8-bit data bus: fetch, decode, execute.
//  Consumes the decoded opcode type and register fields, then drives every datapath
//  strobe: register file, accumulator, temp reg, ALU, flags, memory and PC increment.
//  Guarantees at most one bus driver per cycle and handshakes memory via i_mem_ready.
// PARAMETERS
//  OPCODE_TYPE_LENGTH  4     width of i_opcode_type
//  ALU_OPCODE_WIDTH    3     width of o_alu_control
//  ADDR_LENGTH         3     register file address width
//  MEM_TIMEOUT         255   max wait cycles on i_mem_ready before bus error (>=1)
// PORTS
//  i_clk                 in   1   clock, all state changes on rising edge
//  i_reset               in   1   synchronous, active-low reset
//  i_opcode_type         in   OPCODE_TYPE_LENGTH  decoded type, valid in DECODE
//  i_addr_A              in   ADDR_LENGTH  destination reg / ALU op select
//  i_addr_B              in   ADDR_LENGTH  source reg
//  i_mem_ready           in   1   memory completes current rd/wr this cycle
//  i_wake                in   1   leave HALT
//  o_inst_reg_wr         out  1   load instruction register from bus
//  o_pc_inc              out  1   PC <- PC+1 at this edge
//  o_addr_sel            out  1   0: memory address = PC, 1: HL
//  o_register_file_addr  out  ADDR_LENGTH
//  o_register_file_wr/_rd out 1   register file write / bus drive
//  o_accumulator_reg_wr  out  1
//  o_tmp_reg_wr/_rd      out  1
//  o_alu_control         out  ALU_OPCODE_WIDTH
//  o_alu_rd, o_flags_reg_rd  out 1   ALU result / flags drive bus
//  o_rd_mem, o_wr_mem    out  1   memory read (drives bus) / write request
//  o_halted, o_bus_error out  1   status; o_illegal out 1 one-cycle pulse
// BEHAVIOUR
//  - Reset (i_reset==0 at edge): state=FETCH, wait counter=0, all strobes/status 0,
//    addr/control outputs 0. Reset wins over any state, incl. mid memory wait.
//  - All outputs decoded from registered state (Moore); no input->output comb path
//    except that memory states hold requests while i_mem_ready==0.
//  - FETCH: o_rd_mem=1, o_addr_sel=0; when i_mem_ready: o_inst_reg_wr=1, o_pc_inc=1,
//    -> DECODE. DECODE (1 cycle, no strobes): branch on i_opcode_type:
//    0 NOP -> FETCH | 1 LD r,r' -> MOVE | 2 LD r,imm -> IMM_REG | 3 ALU r -> TMP_LD
//    4 ALU imm -> IMM_TMP | 5 LD r,(HL) -> HL_RD | 6 LD (HL),r -> HL_WR | 7 HALT -> HALT
//    8..15: o_illegal pulse next cycle, treated as NOP.
//  - MOVE: rf_addr=B, rf_rd=1 ... single cycle: rf_rd of B and rf_wr of A are split:
//    MOVE_RD (rf_rd, tmp_wr, addr=B) -> MOVE_WR (tmp_rd, rf_wr, addr=A) -> FETCH.
//  - IMM_REG: rd_mem, addr_sel=0, rf_wr addr=A; on ready also pc_inc -> FETCH.
//  - IMM_TMP: rd_mem, tmp_wr; on ready pc_inc -> ALU_EXE.
//  - TMP_LD: rf_rd addr=B, tmp_wr -> ALU_EXE.
//  - ALU_EXE: alu_control=A field, alu_rd, acc_wr -> FETCH (flags reg loads itself).
//  - HL_RD: rd_mem, addr_sel=1, rf_wr addr=A; on ready -> FETCH.
//  - HL_WR: wr_mem, addr_sel=1, rf_rd addr=B; on ready -> FETCH.
//  - HALT: o_halted=1, no strobes; i_wake=1 -> FETCH (next cycle halted=0).
//  - Memory wait: counter increments each cycle ready==0 in a memory state, clears on
//    ready. Reaching MEM_TIMEOUT -> BUS_ERR: all strobes 0, o_bus_error=1, sticky
//    until reset. ready arriving on the timeout cycle counts as success.
//  - Invariant: at most one of rf_rd, tmp_rd, alu_rd, flags_reg_rd, rd_mem per cycle;
//    rd_mem and wr_mem never together. o_flags_reg_rd stays 0 (reserved).
//  - Cycle counts with ready always 1: NOP 2, LD r,imm 3, LD r,r' 4, ALU r 4,
//    ALU imm 4, LD r,(HL) 3, LD (HL),r 3.
// TESTING
//  - Reset then ready=1, type=0 repeated -> inst_reg_wr & pc_inc every 2nd cycle.
//  - type=1, A=2, B=5 -> MOVE_RD rf_addr=5 rf_rd tmp_wr; MOVE_WR rf_addr=2 rf_wr tmp_rd.
//  - type=3, A=3'b010, B=1 -> TMP_LD then ALU_EXE alu_control=2, acc_wr, alu_rd; 4 cycles.
//  - type=6 with ready low 3 cycles -> wr_mem & addr_sel held 4 cycles, then FETCH.
//  - ready stuck 0, MEM_TIMEOUT=4 -> bus_error=1 after 4 wait cycles, sticky; reset clears.
//  - type=7 -> halted=1 no strobes; wake=1 -> FETCH; type=12 -> one o_illegal pulse.

Source files
------------

// File: rtl/gb80_micro_sequencer.sv
// gb80 fetch/decode/execute sequencer: a Moore FSM that owns every datapath strobe
// and guarantees a single driver on the shared 8-bit data bus each cycle.
module gb80_micro_sequencer #(
    parameter int OPCODE_TYPE_LENGTH = 4,
    parameter int ALU_OPCODE_WIDTH   = 3,
    parameter int ADDR_LENGTH        = 3,
    parameter int MEM_TIMEOUT        = 255
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic [OPCODE_TYPE_LENGTH-1:0] i_opcode_type,
    input  logic [ADDR_LENGTH-1:0]        i_addr_A,
    input  logic [ADDR_LENGTH-1:0]        i_addr_B,
    input  logic                          i_mem_ready,
    input  logic                          i_wake,
    output logic                          o_inst_reg_wr,
    output logic                          o_pc_inc,
    output logic                          o_addr_sel,
    output logic [ADDR_LENGTH-1:0]        o_register_file_addr,
    output logic                          o_register_file_wr,
    output logic                          o_register_file_rd,
    output logic                          o_accumulator_reg_wr,
    output logic                          o_tmp_reg_wr,
    output logic                          o_tmp_reg_rd,
    output logic [ALU_OPCODE_WIDTH-1:0]   o_alu_control,
    output logic                          o_alu_rd,
    output logic                          o_flags_reg_rd,
    output logic                          o_rd_mem,
    output logic                          o_wr_mem,
    output logic                          o_halted,
    output logic                          o_bus_error,
    output logic                          o_illegal,
    output logic [3:0]                    o_dbg_state
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MOVE_RD, S_MOVE_WR, S_IMM_REG, S_IMM_TMP,
        S_TMP_LD, S_ALU_EXE, S_HL_RD, S_HL_WR, S_HALT, S_BUS_ERR
    } state_t;

    localparam int                CNT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t                  r_state;
    state_t                  w_next;
    logic [CNT_W-1:0]        r_wait_cnt;
    logic [ADDR_LENGTH-1:0]  r_addr_a;
    logic [ADDR_LENGTH-1:0]  r_addr_b;
    logic                    r_illegal;
    logic                    w_mem_state;
    logic                    w_timeout;

    // Memory handshake: a request (o_rd_mem/o_wr_mem) is held every cycle until the
    // cycle in which i_mem_ready is high; that cycle completes the transfer.
    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_IMM_REG) ||
                         (r_state == S_IMM_TMP) || (r_state == S_HL_RD) ||
                         (r_state == S_HL_WR);
    assign w_timeout   = w_mem_state && !i_mem_ready && (r_wait_cnt == CNT_LAST);
    assign o_dbg_state = r_state;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
            r_addr_a   <= '0;
            r_addr_b   <= '0;
            r_illegal  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= (r_state == S_DECODE) &&
                         (i_opcode_type > OPCODE_TYPE_LENGTH'(7));
            if (w_mem_state && !i_mem_ready && !w_timeout)
                r_wait_cnt <= r_wait_cnt + 1'b1;
            else
                r_wait_cnt <= '0;
            if (r_state == S_DECODE) begin
                r_addr_a <= i_addr_A;
                r_addr_b <= i_addr_B;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:   if (i_mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (i_opcode_type)
                    OPCODE_TYPE_LENGTH'(1): w_next = S_MOVE_RD;
                    OPCODE_TYPE_LENGTH'(2): w_next = S_IMM_REG;
                    OPCODE_TYPE_LENGTH'(3): w_next = S_TMP_LD;
                    OPCODE_TYPE_LENGTH'(4): w_next = S_IMM_TMP;
                    OPCODE_TYPE_LENGTH'(5): w_next = S_HL_RD;
                    OPCODE_TYPE_LENGTH'(6): w_next = S_HL_WR;
                    OPCODE_TYPE_LENGTH'(7): w_next = S_HALT;
                    default:                w_next = S_FETCH;
                endcase
            end
            S_MOVE_RD: w_next = S_MOVE_WR;
            S_MOVE_WR: w_next = S_FETCH;
            S_IMM_REG: if (i_mem_ready) w_next = S_FETCH;
            S_IMM_TMP: if (i_mem_ready) w_next = S_ALU_EXE;
            S_TMP_LD:  w_next = S_ALU_EXE;
            S_ALU_EXE: w_next = S_FETCH;
            S_HL_RD:   if (i_mem_ready) w_next = S_FETCH;
            S_HL_WR:   if (i_mem_ready) w_next = S_FETCH;
            S_HALT:    if (i_wake) w_next = S_FETCH;
            S_BUS_ERR: w_next = S_BUS_ERR;
            default:   w_next = S_FETCH;
        endcase
        if (w_timeout) w_next = S_BUS_ERR;
    end

    // Outputs are blanked while reset is asserted so the bus stays quiet.
    always_comb begin
        o_inst_reg_wr        = 1'b0;
        o_pc_inc             = 1'b0;
        o_addr_sel           = 1'b0;
        o_register_file_addr = '0;
        o_register_file_wr   = 1'b0;
        o_register_file_rd   = 1'b0;
        o_accumulator_reg_wr = 1'b0;
        o_tmp_reg_wr         = 1'b0;
        o_tmp_reg_rd         = 1'b0;
        o_alu_control        = '0;
        o_alu_rd             = 1'b0;
        o_flags_reg_rd       = 1'b0;
        o_rd_mem             = 1'b0;
        o_wr_mem             = 1'b0;
        o_halted             = 1'b0;
        o_bus_error          = 1'b0;
        o_illegal            = i_reset & r_illegal;
        if (i_reset) begin
            case (r_state)
                S_FETCH: begin
                    o_rd_mem      = 1'b1;
                    o_inst_reg_wr = i_mem_ready;
                    o_pc_inc      = i_mem_ready;
                end
                S_MOVE_RD: begin
                    o_register_file_addr = r_addr_b;
                    o_register_file_rd   = 1'b1;
                    o_tmp_reg_wr         = 1'b1;
                end
                S_MOVE_WR: begin
                    o_register_file_addr = r_addr_a;
                    o_register_file_wr   = 1'b1;
                    o_tmp_reg_rd         = 1'b1;
                end
                S_IMM_REG: begin
                    o_rd_mem             = 1'b1;
                    o_register_file_addr = r_addr_a;
                    o_register_file_wr   = 1'b1;
                    o_pc_inc             = i_mem_ready;
                end
                S_IMM_TMP: begin
                    o_rd_mem     = 1'b1;
                    o_tmp_reg_wr = 1'b1;
                    o_pc_inc     = i_mem_ready;
                end
                S_TMP_LD: begin
                    o_register_file_addr = r_addr_b;
                    o_register_file_rd   = 1'b1;
                    o_tmp_reg_wr         = 1'b1;
                end
                S_ALU_EXE: begin
                    o_alu_control        = ALU_OPCODE_WIDTH'(r_addr_a);
                    o_alu_rd             = 1'b1;
                    o_accumulator_reg_wr = 1'b1;
                end
                S_HL_RD: begin
                    o_rd_mem             = 1'b1;
                    o_addr_sel           = 1'b1;
                    o_register_file_addr = r_addr_a;
                    o_register_file_wr   = 1'b1;
                end
                S_HL_WR: begin
                    o_wr_mem             = 1'b1;
                    o_addr_sel           = 1'b1;
                    o_register_file_addr = r_addr_b;
                    o_register_file_rd   = 1'b1;
                end
                S_HALT:    o_halted    = 1'b1;
                S_BUS_ERR: o_bus_error = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gb80_micro_sequencer.sv
// Directed bench for gb80_micro_sequencer: a vector table for each instruction type
// plus hand-written memory-wait, timeout, reset and halt sequences.
module tb_gb80_micro_sequencer;

    localparam logic [14:0] IRW  = 15'h4000, PCI  = 15'h2000, ASEL = 15'h1000,
                            RFW  = 15'h0800, RFR  = 15'h0400, ACCW = 15'h0200,
                            TMPW = 15'h0100, TMPR = 15'h0080, ALUR = 15'h0040,
                            FLGR = 15'h0020, RDM  = 15'h0010, WRM  = 15'h0008,
                            HLT  = 15'h0004, BERR = 15'h0002, ILL  = 15'h0001;
    localparam logic [14:0] F = RDM | IRW | PCI;
    localparam logic [14:0] Z = 15'h0000;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b0;
    logic [3:0] i_opcode_type = '0;
    logic [2:0] i_addr_A = '0;
    logic [2:0] i_addr_B = '0;
    logic       i_mem_ready = 1'b1;
    logic       i_wake = 1'b0;
    logic       o_inst_reg_wr, o_pc_inc, o_addr_sel;
    logic [2:0] o_register_file_addr;
    logic       o_register_file_wr, o_register_file_rd, o_accumulator_reg_wr;
    logic       o_tmp_reg_wr, o_tmp_reg_rd;
    logic [2:0] o_alu_control;
    logic       o_alu_rd, o_flags_reg_rd, o_rd_mem, o_wr_mem;
    logic       o_halted, o_bus_error, o_illegal;
    logic [3:0] o_dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    gb80_micro_sequencer #(.MEM_TIMEOUT(4)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_opcode_type(i_opcode_type),
        .i_addr_A(i_addr_A), .i_addr_B(i_addr_B), .i_mem_ready(i_mem_ready),
        .i_wake(i_wake), .o_inst_reg_wr(o_inst_reg_wr), .o_pc_inc(o_pc_inc),
        .o_addr_sel(o_addr_sel), .o_register_file_addr(o_register_file_addr),
        .o_register_file_wr(o_register_file_wr), .o_register_file_rd(o_register_file_rd),
        .o_accumulator_reg_wr(o_accumulator_reg_wr), .o_tmp_reg_wr(o_tmp_reg_wr),
        .o_tmp_reg_rd(o_tmp_reg_rd), .o_alu_control(o_alu_control), .o_alu_rd(o_alu_rd),
        .o_flags_reg_rd(o_flags_reg_rd), .o_rd_mem(o_rd_mem), .o_wr_mem(o_wr_mem),
        .o_halted(o_halted), .o_bus_error(o_bus_error), .o_illegal(o_illegal),
        .o_dbg_state(o_dbg_state)
    );

    // Clock and watchdog
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Bus-driver exclusivity checked on every falling edge out of reset
    always @(negedge i_clk) begin
        if (i_reset) begin
            n_checks++;
            if ((int'(o_register_file_rd) + int'(o_tmp_reg_rd) + int'(o_alu_rd) +
                 int'(o_flags_reg_rd) + int'(o_rd_mem)) > 1 || (o_rd_mem && o_wr_mem)
                || o_flags_reg_rd) begin
                n_fail++;
                $display("FAIL bus_exclusive: rf_rd=%b tmp_rd=%b alu_rd=%b flg_rd=%b rd=%b wr=%b",
                         o_register_file_rd, o_tmp_reg_rd, o_alu_rd, o_flags_reg_rd,
                         o_rd_mem, o_wr_mem);
            end
        end
    end

    typedef struct {
        logic       rdy;
        logic [3:0] typ;
        logic [2:0] a;
        logic [2:0] b;
        logic       wk;
        logic [14:0] es;
        logic [2:0] ea;
        logic [2:0] ec;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rdy, logic [3:0] typ, logic [2:0] a, logic [2:0] b,
                                logic wk, logic [14:0] es, logic [2:0] ea, logic [2:0] ec);
        vec_t v;
        v.rdy = rdy; v.typ = typ; v.a = a; v.b = b; v.wk = wk;
        v.es = es; v.ea = ea; v.ec = ec;
        return v;
    endfunction

    task automatic check(input string nm, input logic [14:0] es, input logic [2:0] ea,
                         input logic [2:0] ec);
        logic [14:0] got;
        got = {o_inst_reg_wr, o_pc_inc, o_addr_sel, o_register_file_wr, o_register_file_rd,
               o_accumulator_reg_wr, o_tmp_reg_wr, o_tmp_reg_rd, o_alu_rd, o_flags_reg_rd,
               o_rd_mem, o_wr_mem, o_halted, o_bus_error, o_illegal};
        n_checks++;
        if (got !== es || o_register_file_addr !== ea || o_alu_control !== ec) begin
            n_fail++;
            $display("FAIL %s: got strobes=%b addr=%0d alu=%0d, want strobes=%b addr=%0d alu=%0d",
                     nm, got, o_register_file_addr, o_alu_control, es, ea, ec);
        end
    endtask

    // Drive one cycle of inputs, check settled outputs, then advance past the edge
    task automatic cyc(input string nm, input logic rdy, input logic [3:0] typ,
                       input logic [2:0] a, input logic [2:0] b, input logic wk,
                       input logic [14:0] es, input logic [2:0] ea, input logic [2:0] ec);
        i_mem_ready   = rdy;
        i_opcode_type = typ;
        i_addr_A      = a;
        i_addr_B      = b;
        i_wake        = wk;
        #1;
        check(nm, es, ea, ec);
        @(posedge i_clk);
        #2;
    endtask

    initial begin
        // NOP x2
        tbl.push_back(mk(1, 0, 0, 0, 0, F, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, Z, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, F, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, Z, 0, 0));
        // LD r,r' A=2 B=5
        tbl.push_back(mk(1, 1, 2, 5, 0, F, 0, 0));
        tbl.push_back(mk(1, 1, 2, 5, 0, Z, 0, 0));
        tbl.push_back(mk(1, 1, 2, 5, 0, RFR | TMPW, 5, 0));
        tbl.push_back(mk(1, 1, 2, 5, 0, TMPR | RFW, 2, 0));
        // ALU r A=2 B=1
        tbl.push_back(mk(1, 3, 2, 1, 0, F, 0, 0));
        tbl.push_back(mk(1, 3, 2, 1, 0, Z, 0, 0));
        tbl.push_back(mk(1, 3, 2, 1, 0, RFR | TMPW, 1, 0));
        tbl.push_back(mk(1, 3, 2, 1, 0, ALUR | ACCW, 0, 2));
        // LD r,imm A=4
        tbl.push_back(mk(1, 2, 4, 0, 0, F, 0, 0));
        tbl.push_back(mk(1, 2, 4, 0, 0, Z, 0, 0));
        tbl.push_back(mk(1, 2, 4, 0, 0, RDM | RFW | PCI, 4, 0));
        // ALU imm A=5
        tbl.push_back(mk(1, 4, 5, 0, 0, F, 0, 0));
        tbl.push_back(mk(1, 4, 5, 0, 0, Z, 0, 0));
        tbl.push_back(mk(1, 4, 5, 0, 0, RDM | TMPW | PCI, 0, 0));
        tbl.push_back(mk(1, 4, 5, 0, 0, ALUR | ACCW, 0, 5));
        // LD r,(HL) A=6
        tbl.push_back(mk(1, 5, 6, 0, 0, F, 0, 0));
        tbl.push_back(mk(1, 5, 6, 0, 0, Z, 0, 0));
        tbl.push_back(mk(1, 5, 6, 0, 0, RDM | ASEL | RFW, 6, 0));
        // LD (HL),r B=3
        tbl.push_back(mk(1, 6, 0, 3, 0, F, 0, 0));
        tbl.push_back(mk(1, 6, 0, 3, 0, Z, 0, 0));
        tbl.push_back(mk(1, 6, 0, 3, 0, WRM | ASEL | RFR, 3, 0));
        // illegal type 12: behaves as NOP with a one-cycle pulse
        tbl.push_back(mk(1, 12, 0, 0, 0, F, 0, 0));
        tbl.push_back(mk(1, 12, 0, 0, 0, Z, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, F | ILL, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, Z, 0, 0));
        // HALT then wake
        tbl.push_back(mk(1, 7, 0, 0, 0, F, 0, 0));
        tbl.push_back(mk(1, 7, 0, 0, 0, Z, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, HLT, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, HLT, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, HLT, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, F, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, Z, 0, 0));

        // Reset state
        i_reset = 1'b0;
        repeat (2) @(posedge i_clk);
        #2;
        #1;
        check("reset_outputs", Z, 0, 0);
        i_reset = 1'b1;

        foreach (tbl[i])
            cyc($sformatf("tbl[%0d]", i), tbl[i].rdy, tbl[i].typ, tbl[i].a, tbl[i].b,
                tbl[i].wk, tbl[i].es, tbl[i].ea, tbl[i].ec);

        // LD (HL),r with three wait cycles: request held four cycles
        cyc("hlwr_fetch", 1, 6, 0, 4, 0, F, 0, 0);
        cyc("hlwr_decode", 1, 6, 0, 4, 0, Z, 0, 0);
        for (int k = 0; k < 3; k++)
            cyc($sformatf("hlwr_wait%0d", k), 0, 6, 0, 4, 0, WRM | ASEL | RFR, 4, 0);
        cyc("hlwr_done", 1, 6, 0, 4, 0, WRM | ASEL | RFR, 4, 0);
        cyc("hlwr_next_fetch", 1, 0, 0, 0, 0, F, 0, 0);
        cyc("hlwr_next_decode", 1, 0, 0, 0, 0, Z, 0, 0);

        // Ready arriving on the last allowed cycle completes the fetch
        for (int k = 0; k < 3; k++)
            cyc($sformatf("late_wait%0d", k), 0, 0, 0, 0, 0, RDM, 0, 0);
        cyc("late_ready", 1, 0, 0, 0, 0, F, 0, 0);
        cyc("late_decode", 1, 0, 0, 0, 0, Z, 0, 0);

        // Reset during a memory wait also clears the wait counter
        cyc("midrst_fetch", 1, 6, 0, 2, 0, F, 0, 0);
        cyc("midrst_decode", 1, 6, 0, 2, 0, Z, 0, 0);
        cyc("midrst_wait0", 0, 6, 0, 2, 0, WRM | ASEL | RFR, 2, 0);
        cyc("midrst_wait1", 0, 6, 0, 2, 0, WRM | ASEL | RFR, 2, 0);
        i_reset = 1'b0;
        cyc("midrst_in_reset", 0, 0, 0, 0, 0, Z, 0, 0);
        i_reset = 1'b1;
        for (int k = 0; k < 3; k++)
            cyc($sformatf("midrst_refetch%0d", k), 0, 0, 0, 0, 0, RDM, 0, 0);
        cyc("midrst_ready", 1, 0, 0, 0, 0, F, 0, 0);
        cyc("midrst_decode", 1, 0, 0, 0, 0, Z, 0, 0);

        // Ready stuck low: bus error after four wait cycles, sticky until reset
        for (int k = 0; k < 4; k++)
            cyc($sformatf("tmo_wait%0d", k), 0, 0, 0, 0, 0, RDM, 0, 0);
        cyc("tmo_bus_err0", 0, 0, 0, 0, 0, BERR, 0, 0);
        cyc("tmo_sticky_ready", 1, 0, 0, 0, 0, BERR, 0, 0);
        cyc("tmo_sticky_wake", 1, 0, 0, 0, 1, BERR, 0, 0);
        i_reset = 1'b0;
        cyc("tmo_in_reset", 1, 0, 0, 0, 0, Z, 0, 0);
        i_reset = 1'b1;
        cyc("tmo_after_reset", 1, 0, 0, 0, 0, F, 0, 0);
        cyc("tmo_after_decode", 1, 0, 0, 0, 0, Z, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
